fp16_mant_mul_seq: RTL

- Upstream stage of the FP16 MAC normaliser. Accepts two FP16 operands, computes sign and biased result exponent, and forms the raw 22-bit significand product with an iterative shift-add multiplier.
- Output pair `Out_m[21:0]` / `E_r[4:0]` is in exactly the format the normaliser consumes: product of two 1.10 significands, hidden-one at bit 20 or 21.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fp16_mac_pkg.sv | 34 +++
 rtl/fp16_exp_sign_unit.sv | 63 ++++++
 rtl/fp16_mant_mul_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fp16_mac_pkg.sv
// Shared FP16 MAC definitions: field widths, FSM encoding, field extractors.
// Used by the multiplier, normaliser and adder stages.
package fp16_mac_pkg;

    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int PROD_W   = 22;
    localparam int EXP_BIAS = 15;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic sign_f(input logic [15:0] x);
        return x[15];
    endfunction

    function automatic logic [EXP_W-1:0] exp_f(input logic [15:0] x);
        return x[14:10];
    endfunction

    function automatic logic [MAN_W-1:0] man_f(input logic [15:0] x);
        return x[9:0];
    endfunction

    // Significand with the hidden one restored (1.10 format)
    function automatic logic [MAN_W:0] sig_f(input logic [15:0] x);
        return {1'b1, x[9:0]};
    endfunction

endpackage

// File: rtl/fp16_exp_sign_unit.sv
// Combinational sign/exponent classifier for the FP16 significand multiplier.
// Inf/NaN handling is enabled by defining FP16_MUL_INF_NAN_EN.
module fp16_exp_sign_unit #(
    parameter int EXP_BIAS = fp16_mac_pkg::EXP_BIAS
) (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        sign,
    output logic [10:0] sig_a,
    output logic [10:0] sig_b,
    output logic [4:0]  e_res,
    output logic        zero,
    output logic        ovf,
    output logic        special,
    output logic        nan
);
    import fp16_mac_pkg::*;

    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic signed [6:0] esum;
    logic raw_zero;
    logic big;

    assign ea    = exp_f(a);
    assign eb    = exp_f(b);
    assign sign  = sign_f(a) ^ sign_f(b);
    assign sig_a = sig_f(a);
    assign sig_b = sig_f(b);

    assign esum = signed'({2'b00, ea} + {2'b00, eb} - 7'(EXP_BIAS));

    // Subnormal operands are flushed, so exponent field 0 means zero
    assign raw_zero = (ea == '0) || (eb == '0) || (esum <= 7'sd0);
    assign big      = (esum >= 7'sd31);

`ifdef FP16_MUL_INF_NAN_EN
    logic a_max;
    logic b_max;

    assign a_max   = (ea == EXP_MAX);
    assign b_max   = (eb == EXP_MAX);
    assign special = a_max || b_max;
    // NaN operand, or Inf times zero
    assign nan     = (a_max && (man_f(a) != '0))
                  || (b_max && (man_f(b) != '0))
                  || (a_max && (eb == '0))
                  || (b_max && (ea == '0));
    assign zero    = !special && raw_zero;
    assign ovf     = !special && !raw_zero && big;
`else
    assign special = 1'b0;
    assign nan     = 1'b0;
    assign zero    = raw_zero;
    assign ovf     = !raw_zero && big;
`endif

    assign e_res = special ? EXP_MAX
                 : zero    ? 5'd0
                 : ovf     ? EXP_MAX
                 : esum[4:0];

endmodule

// File: rtl/fp16_mant_mul_seq.sv
// FP16 significand multiplier stage: iterative shift-add over the 12-bit
// zero-padded multiplier, BITS_PER_CYCLE bits retired per BUSY cycle.
module fp16_mant_mul_seq #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int EXP_BIAS       = fp16_mac_pkg::EXP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [21:0] Out_m,
    output logic [4:0]  E_r,
    output logic        S_r,
    output logic        is_zero,
    output logic        ovf,
    output logic        special
);
    import fp16_mac_pkg::*;

    localparam int NSTEP = 12 / BITS_PER_CYCLE;
    localparam logic [3:0] LAST = 4'(NSTEP - 1);

    state_t state;
    state_t nxt;

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] acc_nxt;
    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] pp;
    logic [11:0] mplier;
    logic [3:0]  step;
    logic [4:0]  e_q;
    logic s_q;
    logic o_q;

    logic c_sign;
    logic [10:0] c_sig_a;
    logic [10:0] c_sig_b;
    logic [4:0]  c_e_res;
    logic c_zero;
    logic c_ovf;
    logic c_special;
    logic c_nan;
    logic short_path;
    logic last;

    fp16_exp_sign_unit #(
        .EXP_BIAS(EXP_BIAS)
    ) u_cls (
        .a       (A),
        .b       (B),
        .sign    (c_sign),
        .sig_a   (c_sig_a),
        .sig_b   (c_sig_b),
        .e_res   (c_e_res),
        .zero    (c_zero),
        .ovf     (c_ovf),
        .special (c_special),
        .nan     (c_nan)
    );

    assign short_path = c_zero || c_special;
    assign last       = (step == LAST);
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) pp = pp + (mcand << i);
        end
    end

    assign acc_nxt = acc + pp;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (in_valid) nxt = short_path ? DONE : BUSY;
            BUSY: if (last) nxt = DONE;
            DONE: if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            step    <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            o_q     <= 1'b0;
            Out_m   <= '0;
            E_r     <= '0;
            S_r     <= 1'b0;
            is_zero <= 1'b0;
            ovf     <= 1'b0;
            special <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= '0;
                        mcand  <= {11'd0, c_sig_a};
                        mplier <= {1'b0, c_sig_b};
                        step   <= '0;
                        e_q    <= c_e_res;
                        s_q    <= c_sign;
                        o_q    <= c_ovf;
                        // Zero and special results bypass the multiply
                        if (short_path) begin
                            Out_m   <= c_nan ? 22'h200000 : 22'h0;
                            E_r     <= c_e_res;
                            S_r     <= c_sign;
                            is_zero <= c_zero;
                            ovf     <= 1'b0;
                            special <= c_special;
                        end
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    step   <= step + 4'd1;
                    if (last) begin
                        Out_m   <= acc_nxt;
                        E_r     <= e_q;
                        S_r     <= s_q;
                        is_zero <= 1'b0;
                        ovf     <= o_q;
                        special <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
